// File: rtl/vm2002_coin_unit.sv
// Coin-handling stage for the vm2002 vending controller.
// Collects coins into a credit, arbitrates purchase/timeout/cancel, and pays out change greedily.
module vm2002_coin_unit #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CREDIT_W       = 10,
  parameter int MAX_CREDIT     = 500
) (
  input  logic                clk,
  input  logic                hrst,
  input  logic                srst,
  input  logic                insert_coins,
  input  logic                select,
  input  logic [CREDIT_W-1:0] cost,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                timeout,
  output logic                insufficient_amount,
  output logic                vend,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  input  logic                change_ready,
  output logic                change_done,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHANGE} state_e;

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] NICKEL     = CREDIT_W'(5);
  localparam logic [CREDIT_W:0]   CREDIT_CAP = (CREDIT_W+1)'(MAX_CREDIT);

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] t);
    case (t)
      2'b00:   return CREDIT_W'(5);
      2'b01:   return CREDIT_W'(10);
      2'b10:   return CREDIT_W'(25);
      default: return CREDIT_W'(100);
    endcase
  endfunction

  function automatic logic [1:0] largest_coin(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(100))     return 2'b11;
    else if (c >= CREDIT_W'(25)) return 2'b10;
    else if (c >= CREDIT_W'(10)) return 2'b01;
    else                         return 2'b00;
  endfunction

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic coin_accept_q, coin_accept_d;
  logic coin_reject_q, coin_reject_d;
  logic timeout_q, timeout_d;
  logic insufficient_q, insufficient_d;
  logic vend_q, vend_d;
  logic change_done_q, change_done_d;

  logic [CREDIT_W:0]   coin_sum;
  logic [1:0]          pay_coin;
  logic [CREDIT_W-1:0] pay_rem;

  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value(coin_type)};
  assign pay_coin = largest_coin(credit_q);
  assign pay_rem  = credit_q - coin_value(pay_coin);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    timer_d        = timer_q;
    coin_accept_d  = 1'b0;
    coin_reject_d  = 1'b0;
    timeout_d      = 1'b0;
    insufficient_d = 1'b0;
    vend_d         = 1'b0;
    change_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        coin_reject_d = coin_valid;
        if (insert_coins) begin
          state_d = S_COLLECT;
          timer_d = '0;
        end
      end

      S_COLLECT: begin
        if (srst || timer_q == TIMER_LAST) begin
          // Cancel and inactivity share the refund path; nothing to refund skips CHANGE.
          timeout_d     = !srst;
          coin_reject_d = coin_valid;
          timer_d       = '0;
          if (credit_q == '0) begin
            change_done_d = 1'b1;
            state_d       = S_IDLE;
          end else begin
            state_d = S_CHANGE;
          end
        end else if (select && credit_q >= cost) begin
          vend_d        = 1'b1;
          coin_reject_d = coin_valid;
          credit_d      = credit_q - cost;
          timer_d       = '0;
          state_d       = (credit_q != cost) ? S_CHANGE : S_IDLE;
        end else if (select) begin
          insufficient_d = 1'b1;
          coin_reject_d  = coin_valid;
          timer_d        = '0;
        end else if (coin_valid && coin_sum <= CREDIT_CAP) begin
          coin_accept_d = 1'b1;
          credit_d      = coin_sum[CREDIT_W-1:0];
          timer_d       = '0;
        end else begin
          coin_reject_d = coin_valid;
          timer_d       = timer_q + 1'b1;
        end
      end

      S_CHANGE: begin
        coin_reject_d = coin_valid;
        // A sub-nickel leftover (odd cost) cannot be paid out and is forfeited.
        if (credit_q < NICKEL || (change_ready && pay_rem < NICKEL)) begin
          credit_d      = '0;
          change_done_d = 1'b1;
          state_d       = S_IDLE;
        end else if (change_ready) begin
          credit_d = pay_rem;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (hrst) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      timer_q        <= '0;
      coin_accept_q  <= 1'b0;
      coin_reject_q  <= 1'b0;
      timeout_q      <= 1'b0;
      insufficient_q <= 1'b0;
      vend_q         <= 1'b0;
      change_done_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      timer_q        <= timer_d;
      coin_accept_q  <= coin_accept_d;
      coin_reject_q  <= coin_reject_d;
      timeout_q      <= timeout_d;
      insufficient_q <= insufficient_d;
      vend_q         <= vend_d;
      change_done_q  <= change_done_d;
    end
  end

  assign coin_accept         = coin_accept_q;
  assign coin_reject         = coin_reject_q;
  assign credit              = credit_q;
  assign timeout             = timeout_q;
  assign insufficient_amount = insufficient_q;
  assign vend                = vend_q;
  assign change_done         = change_done_q;
  assign change_valid        = (state_q == S_CHANGE) && (credit_q >= NICKEL);
  assign change_coin         = pay_coin;
  assign busy                = (state_q != S_IDLE);

endmodule

// File: tb/tb_vm2002_coin_unit.sv
// Directed bench for vm2002_coin_unit: purchase, shortfall, timeout, cap, stall and hard-reset scenarios.
module tb_vm2002_coin_unit;

  localparam int T_CYC = 16;
  localparam int CW    = 10;

  logic          clk = 1'b0;
  logic          hrst = 1'b0, srst = 1'b0, insert_coins = 1'b0, select = 1'b0;
  logic [CW-1:0] cost = '0;
  logic          coin_valid = 1'b0;
  logic [1:0]    coin_type = 2'b00;
  logic          change_ready = 1'b0;
  logic          coin_accept, coin_reject, timeout, insufficient_amount, vend;
  logic          change_valid, change_done, busy;
  logic [1:0]    change_coin;
  logic [CW-1:0] credit;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] got_seq;
  int          got_n;
  logic        saw_done;

  vm2002_coin_unit #(.TIMEOUT_CYCLES(T_CYC), .CREDIT_W(CW), .MAX_CREDIT(500)) dut (
    .clk(clk), .hrst(hrst), .srst(srst), .insert_coins(insert_coins), .select(select),
    .cost(cost), .coin_valid(coin_valid), .coin_type(coin_type),
    .coin_accept(coin_accept), .coin_reject(coin_reject), .credit(credit),
    .timeout(timeout), .insufficient_amount(insufficient_amount), .vend(vend),
    .change_valid(change_valid), .change_coin(change_coin), .change_ready(change_ready),
    .change_done(change_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    step();
    coin_valid = 1'b0;
  endtask

  task automatic start_collect();
    insert_coins = 1'b1;
    step();
    insert_coins = 1'b0;
  endtask

  task automatic do_select(input int c);
    select = 1'b1;
    cost   = CW'(c);
    step();
    select = 1'b0;
  endtask

  task automatic do_srst();
    srst = 1'b1;
    step();
    srst = 1'b0;
  endtask

  // Accept change with ready high; record offered coins until change_done or the budget runs out.
  task automatic drain(input int budget);
    got_seq = '0; got_n = 0; saw_done = 1'b0;
    change_ready = 1'b1;
    for (int i = 0; i < budget && !saw_done; i++) begin
      if (change_valid) begin
        got_seq = {got_seq[29:0], change_coin};
        got_n++;
      end
      step();
      if (change_done) saw_done = 1'b1;
    end
    change_ready = 1'b0;
  endtask

  task automatic test_reset();
    hrst = 1'b1; step(); step(); hrst = 1'b0;
    n_checks++; if ({credit, busy, change_valid, change_done, vend, coin_accept, timeout} !== '0)
      $display("FAIL reset_outputs got credit=%0d busy=%b cv=%b", credit, busy, change_valid); else n_pass++;
    coin(2'b10);
    n_checks++; if ({coin_reject, coin_accept, credit} !== {2'b10, CW'(0)})
      $display("FAIL idle_coin got rej=%b acc=%b credit=%0d exp rej=1 acc=0 credit=0", coin_reject, coin_accept, credit); else n_pass++;
    start_collect();
    n_checks++; if (busy !== 1'b1) $display("FAIL collect_busy got %b exp 1", busy); else n_pass++;
    do_srst();
    n_checks++; if ({change_done, busy, change_valid} !== 3'b100)
      $display("FAIL zero_refund got done=%b busy=%b cv=%b exp 1 0 0", change_done, busy, change_valid); else n_pass++;
  endtask

  task automatic test_purchase();
    start_collect();
    coin(2'b10);
    n_checks++; if ({coin_accept, credit} !== {1'b1, CW'(25)})
      $display("FAIL p_coin1 got acc=%b credit=%0d exp 1 25", coin_accept, credit); else n_pass++;
    coin(2'b10); coin(2'b01);
    n_checks++; if ({coin_accept, credit} !== {1'b1, CW'(60)})
      $display("FAIL p_coin3 got acc=%b credit=%0d exp 1 60", coin_accept, credit); else n_pass++;
    do_select(50);
    n_checks++; if ({vend, credit, change_valid, change_coin} !== {1'b1, CW'(10), 1'b1, 2'b01})
      $display("FAIL p_vend got vend=%b credit=%0d cv=%b cc=%b exp 1 10 1 01", vend, credit, change_valid, change_coin); else n_pass++;
    drain(20);
    n_checks++; if ({saw_done, got_n, got_seq, credit, busy} !== {1'b1, 32'd1, 32'h1, CW'(0), 1'b0})
      $display("FAIL p_change got done=%b n=%0d seq=%h credit=%0d busy=%b exp 1 1 1 0 0", saw_done, got_n, got_seq, credit, busy); else n_pass++;
  endtask

  task automatic test_insufficient();
    start_collect();
    coin(2'b10);
    do_select(75);
    n_checks++; if ({insufficient_amount, vend, credit, busy} !== {2'b10, CW'(25), 1'b1})
      $display("FAIL i_short got ins=%b vend=%b credit=%0d busy=%b exp 1 0 25 1", insufficient_amount, vend, credit, busy); else n_pass++;
    coin(2'b11);
    n_checks++; if (credit !== CW'(125)) $display("FAIL i_credit got %0d exp 125", credit); else n_pass++;
    do_select(75);
    n_checks++; if ({vend, insufficient_amount, credit, change_coin} !== {2'b10, CW'(50), 2'b10})
      $display("FAIL i_vend got vend=%b ins=%b credit=%0d cc=%b exp 1 0 50 10", vend, insufficient_amount, credit, change_coin); else n_pass++;
    drain(20);
    n_checks++; if ({saw_done, got_n, got_seq} !== {1'b1, 32'd2, 32'hA})
      $display("FAIL i_change got done=%b n=%0d seq=%h exp 1 2 a", saw_done, got_n, got_seq); else n_pass++;
  endtask

  task automatic test_timeout();
    logic early;
    start_collect();
    coin(2'b10); coin(2'b01); coin(2'b01);
    early = 1'b0;
    for (int i = 0; i < T_CYC - 1; i++) begin
      step();
      if (timeout || !busy || change_valid) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) $display("FAIL t_early got 1 exp 0"); else n_pass++;
    step();
    n_checks++; if ({timeout, change_valid, change_coin, credit} !== {2'b11, 2'b10, CW'(45)})
      $display("FAIL t_pulse got to=%b cv=%b cc=%b credit=%0d exp 1 1 10 45", timeout, change_valid, change_coin, credit); else n_pass++;
    step();
    n_checks++; if ({timeout, credit} !== {1'b0, CW'(45)})
      $display("FAIL t_once got to=%b credit=%0d exp 0 45", timeout, credit); else n_pass++;
    drain(20);
    n_checks++; if ({saw_done, got_n, got_seq} !== {1'b1, 32'd3, 32'h25})
      $display("FAIL t_refund got done=%b n=%0d seq=%h exp 1 3 25", saw_done, got_n, got_seq); else n_pass++;
  endtask

  task automatic test_cap();
    start_collect();
    for (int i = 0; i < 4; i++) coin(2'b11);
    coin(2'b10); coin(2'b10);
    coin(2'b11);
    n_checks++; if ({coin_reject, coin_accept, credit} !== {2'b10, CW'(450)})
      $display("FAIL c_over got rej=%b acc=%b credit=%0d exp 1 0 450", coin_reject, coin_accept, credit); else n_pass++;
    coin(2'b10); coin(2'b10);
    n_checks++; if ({coin_accept, credit} !== {1'b1, CW'(500)})
      $display("FAIL c_exact got acc=%b credit=%0d exp 1 500", coin_accept, credit); else n_pass++;
    coin(2'b00);
    n_checks++; if ({coin_reject, credit} !== {1'b1, CW'(500)})
      $display("FAIL c_nickel got rej=%b credit=%0d exp 1 500", coin_reject, credit); else n_pass++;
    do_srst();
    drain(30);
    n_checks++; if ({saw_done, got_n, got_seq, credit} !== {1'b1, 32'd5, 32'h3FF, CW'(0)})
      $display("FAIL c_refund got done=%b n=%0d seq=%h credit=%0d exp 1 5 3ff 0", saw_done, got_n, got_seq, credit); else n_pass++;
  endtask

  task automatic test_stall();
    logic stable, rej_ok;
    start_collect();
    coin(2'b10); coin(2'b01);
    do_srst();
    stable = 1'b1; rej_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin coin_valid = 1'b1; coin_type = 2'b00; end
      step();
      coin_valid = 1'b0;
      if (change_valid !== 1'b1 || change_coin !== 2'b10 || credit !== CW'(35) || change_done) stable = 1'b0;
      if (i == 2 && coin_reject === 1'b1 && coin_accept === 1'b0) rej_ok = 1'b1;
    end
    n_checks++; if (stable !== 1'b1) $display("FAIL s_stable got 0 exp 1"); else n_pass++;
    n_checks++; if (rej_ok !== 1'b1) $display("FAIL s_reject got 0 exp 1"); else n_pass++;
    drain(20);
    n_checks++; if ({saw_done, got_n, got_seq} !== {1'b1, 32'd2, 32'h9})
      $display("FAIL s_drain got done=%b n=%0d seq=%h exp 1 2 9", saw_done, got_n, got_seq); else n_pass++;
  endtask

  task automatic test_hrst_change();
    start_collect();
    coin(2'b10); coin(2'b01);
    do_srst();
    n_checks++; if ({change_valid, credit} !== {1'b1, CW'(35)})
      $display("FAIL h_pre got cv=%b credit=%0d exp 1 35", change_valid, credit); else n_pass++;
    hrst = 1'b1; step(); hrst = 1'b0;
    n_checks++; if ({busy, credit, change_valid, change_done} !== {1'b0, CW'(0), 2'b00})
      $display("FAIL h_post got busy=%b credit=%0d cv=%b done=%b exp 0 0 0 0", busy, credit, change_valid, change_done); else n_pass++;
    step();
    n_checks++; if ({change_done, busy} !== 2'b00)
      $display("FAIL h_nodone got done=%b busy=%b exp 0 0", change_done, busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_purchase();
    test_insufficient();
    test_timeout();
    test_cap();
    test_stall();
    test_hrst_change();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vm2002_coin_unit.md
Name: vm2002_coin_unit

Overview:
- Coin-handling stage directly upstream of the vm2002 vending controller.
- Accepts coins only while the controller asserts insert_coins, and accumulates credit in cents.
- Runs the inactivity timer that produces timeout, and compares credit against the selected item cost on select, producing vend or insufficient_amount.
- Returns change or a full refund to the coin dispenser through a valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 1000, inactivity limit in clocks while collecting (>=2).
- CREDIT_W, 10, width of credit/cost in cents.
- MAX_CREDIT, 500, highest credit allowed; a coin that would exceed it is rejected.

Ports:
- clk  in  1  system clock, all logic on rising edge
- hrst  in  1  hard reset, synchronous, active-high
- srst  in  1  user cancel (soft reset): refund credit
- insert_coins  in  1  controller permits coin entry
- select  in  1  purchase request pulse
- cost  in  CREDIT_W  price of selected item, sampled with select
- coin_valid  in  1  coin presented this cycle
- coin_type  in  2  00=5c, 01=10c, 10=25c, 11=100c
- coin_accept  out  1  one-cycle pulse: coin credited
- coin_reject  out  1  one-cycle pulse: coin returned
- credit  out  CREDIT_W  current credit
- timeout  out  1  one-cycle pulse: inactivity expired
- insufficient_amount  out  1  one-cycle pulse: credit < cost on select
- vend  out  1  one-cycle pulse: purchase approved
- change_valid  out  1  change coin offered
- change_coin  out  2  coin type offered (same encoding)
- change_ready  in  1  dispenser takes coin when change_valid high
- change_done  out  1  one-cycle pulse: change/refund complete
- busy  out  1  high in COLLECT or CHANGE

Behaviour:
- Synchronous hrst, highest priority in any state:
  - state returns to IDLE; credit and timer clear to 0.
  - All outputs 0; pending change is discarded.
- IDLE:
  - Go to COLLECT when insert_coins=1; timer cleared.
  - Any coin_valid in IDLE or CHANGE gives coin_reject the next cycle.
- COLLECT: per cycle, highest priority first:
  1. srst=1: set timer=0, go to CHANGE (full refund). With credit=0, pulse change_done and go to IDLE.
  2. timer==TIMEOUT_CYCLES-1: pulse timeout, go to CHANGE (refund); same credit=0 rule.
  3. select=1 with credit>=cost: credit<=credit-cost, pulse vend. Go to CHANGE if remainder>0, else IDLE.
  4. select=1 with credit<cost: pulse insufficient_amount, clear timer, stay in COLLECT, credit unchanged.
  5. coin_valid=1:
     - If credit+value<=MAX_CREDIT: add value, pulse coin_accept, clear timer.
     - Otherwise pulse coin_reject; timer keeps counting.
  6. Otherwise timer+1.
- Coin handling details:
  - A coin arriving in the same cycle as 1–4 is rejected.
  - All pulses are registered: they appear the cycle after the triggering input and last exactly 1 cycle.
  - credit updates on the same edge as its pulse.
  - insert_coins dropping while in COLLECT has no effect; the unit stays in COLLECT until an exit condition.
- CHANGE:
  - change_valid=1 with change_coin set to the largest coin <= credit (greedy 100/25/10/5).
  - On change_valid&&change_ready, credit<=credit-value.
  - When credit reaches 0: change_valid=0 next cycle, pulse change_done, go to IDLE.
  - change_coin is held stable while change_valid=1 and change_ready=0.
  - srst, select and coins are ignored (coins rejected).
- Arithmetic:
  - Credit is always a multiple of 5; no overflow because of the MAX_CREDIT check.
  - If cost is not a multiple of 5, a leftover under 5c is forfeited: change_done asserts when credit<5 and credit clears to 0.
- busy=1 in COLLECT and CHANGE.

Test Plan:
- hrst, then insert_coins=1; coins 25,25,10; select with cost=50 -> coin_accept ×3, credit=60, vend, change_coin=01 once, change_done, credit=0, IDLE.
- Credit 25, select with cost=75 -> insufficient_amount pulse, credit stays 25; then add 100 and select -> vend, change 25+25 (two 10 handshakes), change_done.
- Credit 45, no activity for TIMEOUT_CYCLES -> timeout pulse exactly once; refund coins 25,10,10; change_done.
- Credit 450, insert 100 -> coin_reject, credit 450; srst -> refund 100×4, 25×2, change_done.
- CHANGE with change_ready held low for 5 cycles -> change_valid and change_coin stable, credit unchanged; coin inserted meanwhile is rejected.
- hrst asserted mid-CHANGE with credit 35 -> next cycle IDLE, credit=0, change_valid=0, no change_done.
